// File: rtl/cpu_pkg.sv
// Shared core definitions: default datapath widths and the operand bundle
// handed from the operand stage to execute.
package cpu_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_REGBITS = 5;
   localparam int DEF_NREGS   = 8;
   localparam int DEF_CTRLW   = 8;

   typedef struct packed {
      logic [DEF_WIDTH-1:0]   a;
      logic [DEF_WIDTH-1:0]   b;
      logic [DEF_REGBITS-1:0] dest;
      logic                   wr;
      logic [DEF_CTRLW-1:0]   ctrl;
   } op_bundle_t;

   // True for an implemented, non-zero register index.
   function automatic logic idx_live(input int idx, input int nregs);
      return (idx != 0) && (idx < nregs);
   endfunction

endpackage

// File: rtl/op_scoreboard.sv
// Pending-write bit per implemented register; set when a writer leaves for
// execute, cleared at writeback, queried for three indices at once.
module op_scoreboard
   import cpu_pkg::*;
#(
   parameter int REGBITS = DEF_REGBITS,
   parameter int NREGS   = DEF_NREGS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    set_i,
   input  logic [REGBITS-1:0]      set_idx_i,
   input  logic                    clr_i,
   input  logic [REGBITS-1:0]      clr_idx_i,
   input  logic [2:0][REGBITS-1:0] q_idx_i,
   output logic [2:0]              q_sb_o
);

   logic [NREGS-1:0] sb_q;
   logic [NREGS-1:0] sb_d;

   // Register 0 is skipped; set is applied last so it wins a collision.
   always_comb begin
      sb_d = sb_q;
      for (int i = 1; i < NREGS; i++) begin
         if (clr_i && clr_idx_i == REGBITS'(i)) sb_d[i] = 1'b0;
         if (set_i && set_idx_i == REGBITS'(i)) sb_d[i] = 1'b1;
      end
   end

   always_comb begin
      q_sb_o = '0;
      for (int k = 0; k < 3; k++) begin
         for (int i = 1; i < NREGS; i++) begin
            if (q_idx_i[k] == REGBITS'(i)) q_sb_o[k] = sb_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_q <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

endmodule

// File: rtl/operand_stage.sv
// Register-read / issue stage with RAW/WAW hazard stalls.
// Define OPSTAGE_WB_BYPASS_EN to forward same-cycle writeback data.
module operand_stage
   import cpu_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int REGBITS = DEF_REGBITS,
   parameter int NREGS   = DEF_NREGS,
   parameter int CTRLW   = DEF_CTRLW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [REGBITS-1:0] in_ra1,
   input  logic [REGBITS-1:0] in_ra2,
   input  logic               in_use1,
   input  logic               in_use2,
   input  logic [REGBITS-1:0] in_dest,
   input  logic               in_wr,
   input  logic [CTRLW-1:0]   in_ctrl,
   output logic [REGBITS-1:0] rf_ra1,
   output logic [REGBITS-1:0] rf_ra2,
   input  logic [WIDTH-1:0]   rf_rd1,
   input  logic [WIDTH-1:0]   rf_rd2,
   input  logic               wb_regwrite,
   input  logic [REGBITS-1:0] wb_wa,
   input  logic [WIDTH-1:0]   wb_wd,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_a,
   output logic [WIDTH-1:0]   out_b,
   output logic [REGBITS-1:0] out_dest,
   output logic               out_wr,
   output logic [CTRLW-1:0]   out_ctrl
);

   logic               valid_q, valid_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [REGBITS-1:0] dest_q, dest_d;
   logic               wr_q, wr_d;
   logic [CTRLW-1:0]   ctrl_q, ctrl_d;

   logic                    in_fire;
   logic                    out_fire;
   logic [2:0][REGBITS-1:0] q_idx;
   logic [2:0]              q_sb;
   logic [2:0]              held;
   logic [2:0]              pend;
   logic [1:0]              byp;
   logic                    raw1, raw2, waw;

   assign rf_ra1 = in_ra1;
   assign rf_ra2 = in_ra2;

   // Slot 0: source 1, slot 1: source 2, slot 2: destination.
   assign q_idx = {in_dest, in_ra2, in_ra1};

   op_scoreboard #(
      .REGBITS (REGBITS),
      .NREGS   (NREGS)
   ) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_i     (out_fire & ~flush & wr_q),
      .set_idx_i (dest_q),
      .clr_i     (wb_regwrite),
      .clr_idx_i (wb_wa),
      .q_idx_i   (q_idx),
      .q_sb_o    (q_sb)
   );

   always_comb begin
      held = '0;
      pend = '0;
      for (int k = 0; k < 3; k++) begin
         held[k] = valid_q & wr_q & (dest_q == q_idx[k])
                 & (q_idx[k] != '0);
         pend[k] = idx_live(int'(q_idx[k]), NREGS)
                 & (q_sb[k] | held[k]);
      end
   end

`ifdef OPSTAGE_WB_BYPASS_EN
   // Only a scoreboard writer can be forwarded; the held bundle has not
   // reached writeback yet.
   always_comb begin
      byp = '0;
      for (int k = 0; k < 2; k++) begin
         byp[k] = q_sb[k] & ~held[k] & wb_regwrite
                & (wb_wa == q_idx[k]);
      end
   end
`else
   assign byp = '0;
`endif

   assign raw1 = in_use1 & pend[0] & ~byp[0];
   assign raw2 = in_use2 & pend[1] & ~byp[1];
   assign waw  = in_wr & pend[2];

   assign in_ready = (~valid_q | out_ready) & ~raw1 & ~raw2
                   & ~waw & ~flush;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = valid_q & out_ready;

   always_comb begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      dest_d  = dest_q;
      wr_d    = wr_q;
      ctrl_d  = ctrl_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (in_fire) begin
         valid_d = 1'b1;
         a_d     = byp[0] ? wb_wd : rf_rd1;
         b_d     = byp[1] ? wb_wd : rf_rd2;
         dest_d  = in_dest;
         wr_d    = in_wr;
         ctrl_d  = in_ctrl;
      end else if (out_fire) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         dest_q  <= '0;
         wr_q    <= 1'b0;
         ctrl_q  <= '0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dest_q  <= dest_d;
         wr_q    <= wr_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign out_valid = valid_q;
   assign out_a     = a_q;
   assign out_b     = b_q;
   assign out_dest  = dest_q;
   assign out_wr    = wr_q;
   assign out_ctrl  = ctrl_q;

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- Register-read/issue stage sitting directly downstream of the register file; one per core.
- Drives regfile read addresses from the decoded instruction and captures the combinational rd1/rd2 results.
- Presents a registered operand bundle to the execute stage over valid/ready.
- Keeps a per-register pending-write scoreboard, stalls RAW/WAW hazards and forwards same-cycle writeback data.

Parameters:
- WIDTH, 8, data width; matches regfile WIDTH.
- REGBITS, 5, register address width; matches regfile REGBITS.
- NREGS, 8, implemented registers; indices >= NREGS are never pending.
- CTRLW, 8, width of the opaque control bundle passed through to execute.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_ra1, in_ra2  in  REGBITS  source register indices.
- in_use1, in_use2  in  1  source is actually read; an unused source never stalls.
- in_dest  in  REGBITS  destination index.
- in_wr  in  1  instruction writes in_dest.
- in_ctrl  in  CTRLW  control bundle.
- rf_ra1, rf_ra2  out  REGBITS  regfile read addresses; combinational copies of in_ra1/in_ra2.
- rf_rd1, rf_rd2  in  WIDTH  regfile read data; combinational, register 0 reads 0.
- wb_regwrite  in  1  writeback commits this cycle; the same signal drives the regfile write port.
- wb_wa  in  REGBITS  writeback address.
- wb_wd  in  WIDTH  writeback data.
- flush  in  1  synchronous kill of the held entry.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_a, out_b  out  WIDTH  operand values.
- out_dest  out  REGBITS  destination index.
- out_wr  out  1  write flag.
- out_ctrl  out  CTRLW  control bundle.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; out_a, out_b, out_dest, out_wr and out_ctrl all 0.
  - Scoreboard sb[NREGS-1:0]=0.
- Fire events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- held(s) = out_valid & out_wr & out_dest==s & s!=0.
- pending(s) = s!=0 & s<NREGS & (sb[s] | held(s)).
- byp(s) = sb[s] & !held(s) & wb_regwrite & wb_wa==s (requires OPSTAGE_WB_BYPASS_EN).
- Hazard terms:
  - raw1 = in_use1 & pending(in_ra1) & !byp(in_ra1); raw2 is the same for source 2.
  - waw = in_wr & pending(in_dest).
- in_ready = (!out_valid | out_ready) & !raw1 & !raw2 & !waw & !flush.
  - in_ready is combinational from the in_* fields, the wb_* inputs and state.
  - in_ready never depends on in_valid.
- On in_fire, the output register loads at the next edge:
  - out_a = byp(ra1) ? wb_wd : rf_rd1; out_b uses the same rule for ra2.
  - An unused source loads the regfile value unchanged.
  - Remaining fields are copied from in_*.
  - out_valid=1.
- Latency is 1 cycle from in_fire to out_valid. Throughput is 1 per cycle when there are no hazards and out_ready=1.
- Without in_fire: out_fire clears out_valid; otherwise the held bundle stays stable, and out_valid stays high until accepted.
- Scoreboard updates:
  - On out_fire with out_wr & out_dest!=0 & out_dest<NREGS: set sb[out_dest].
  - On wb_regwrite with wb_wa!=0 & wb_wa<NREGS: clear sb[wb_wa].
  - If a set and a clear hit the same index in one cycle, set wins. WAW stalling makes this unreachable; it is asserted in verification.
- Register 0: never pending, never stalls, never forwarded.
- flush=1 (priority over all handshakes):
  - Next edge: out_valid=0.
  - in_ready=0 that cycle.
  - No out_fire scoreboard set occurs.
  - Scoreboard is otherwise unchanged; older in-flight writers still write back.
- Reset asserted mid-operation discards the held bundle and clears the scoreboard immediately.

Optional Feature:
- OPSTAGE_WB_BYPASS_EN
- Defined: byp() as above; a RAW on a register committing this cycle proceeds with wb_wd.
- Undefined: byp()=0. A RAW stalls until the cycle after the writeback, then reads the updated regfile. Adds 1 cycle per such dependency; results are identical.

Decomposition:
- Shared package cpu_pkg holds WIDTH, REGBITS, NREGS and CTRLW defaults, plus the operand-bundle struct (a, b, dest, wr, ctrl).
- One natural sub-module, op_scoreboard: holds the sb vector and its set/clear logic, and answers the pending query for three indices.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, sb=0. Issue ADD r3←r1,r2 with r1=5, r2=7 → next cycle out_a=5, out_b=7, out_dest=3.
- RAW through scoreboard: issue r3←…, execute takes it (sb[3]=1). Next instruction reads r3 → in_ready=0. Assert wb_regwrite, wb_wa=3, wb_wd=0x2A:
  - With bypass: accepted that cycle, out_a=0x2A.
  - Without bypass: accepted next cycle, out_a=0x2A.
- Held-entry hazard: out_valid=1, out_dest=4, out_ready=0; incoming reads r4 → in_ready=0 until out_fire, then the scoreboard path applies.
- WAW: sb[6]=1, incoming in_wr=1, in_dest=6 → stall until wb_wa=6 commits. Incoming with in_dest=0 never stalls.
- Backpressure then flush: out_ready=0 for 3 cycles → bundle held stable; flush=1 → out_valid=0 next cycle, sb unchanged, in_ready=0 during the flush cycle.
- Async reset mid-stream: pull rst_n low between edges → out_valid and sb go to 0 immediately; the first post-reset instruction reading r1 is issued without stall.
